// File: rtl/snic_timer_sched.sv
// Multi-channel tick-based timeout scheduler with a round-robin expiry output stage.
// Optional cancel port and logic are enabled by defining SNIC_TIMER_SCHED_CANCEL_EN.
module snic_timer_sched #(
    parameter int unsigned NUM_CH     = 4,
    parameter logic [63:0] TICK_LIMIT = 64'd50_000_000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm_valid,
    input  logic [$clog2(NUM_CH)-1:0] arm_ch,
    input  logic [CNT_W-1:0]          arm_ticks,
`ifdef SNIC_TIMER_SCHED_CANCEL_EN
    input  logic                      cancel_valid,
    input  logic [$clog2(NUM_CH)-1:0] cancel_ch,
`endif
    output logic                      exp_valid,
    output logic [$clog2(NUM_CH)-1:0] exp_ch,
    input  logic                      exp_ready,
    output logic [NUM_CH-1:0]         active,
    output logic [NUM_CH-1:0]         overflow
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PRE_W = (TICK_LIMIT > 64'd1) ? $clog2(TICK_LIMIT) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_LIMIT - 64'd1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t            state;
    logic [PRE_W-1:0]  presc;
    logic              tick;
    logic [CNT_W-1:0]  remain   [NUM_CH];
    logic [CNT_W-1:0]  remain_n [NUM_CH];
    logic [NUM_CH-1:0] active_n;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] arm_hit;
    logic [NUM_CH-1:0] cancel_hit;
    logic [NUM_CH-1:0] pend_keep;
    logic [NUM_CH-1:0] grant_clr;
    logic [CH_W-1:0]   last;
    logic [CH_W-1:0]   grant_ch;
    logic              grant_any;
    logic              advance;

    // Channel index `k` positions after `base`, wrapping at NUM_CH.
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base,
                                               input int unsigned   k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return CH_W'(s);
    endfunction

    // Timebase prescaler; tick is registered one cycle after the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (presc == PRE_LAST);
            presc <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
        end
    end

    // Decode per-channel request strobes; arm wins over cancel on the same channel.
    always_comb begin
        arm_hit    = '0;
        cancel_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arm_hit[i] = arm_valid && (arm_ch == CH_W'(i));
`ifdef SNIC_TIMER_SCHED_CANCEL_EN
            cancel_hit[i] = cancel_valid && (cancel_ch == CH_W'(i)) && !arm_hit[i];
`endif
        end
    end

    // Per-channel countdown: arm loads, cancel stops, tick decrements and expires.
    always_comb begin
        active_n = active;
        expire   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            remain_n[i] = remain[i];
            if (arm_hit[i]) begin
                remain_n[i] = arm_ticks;
                active_n[i] = (arm_ticks != '0);
                expire[i]   = (arm_ticks == '0);
            end else if (cancel_hit[i]) begin
                active_n[i] = 1'b0;
            end else if (tick && active[i]) begin
                remain_n[i] = remain[i] - CNT_W'(1);
                if (remain[i] == CNT_W'(1)) begin
                    active_n[i] = 1'b0;
                    expire[i]   = 1'b1;
                end
            end
        end
    end

    // Round-robin pick among pending channels, starting after the last grant.
    always_comb begin
        grant_any = 1'b0;
        grant_ch  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            if (!grant_any && pending[rr_idx(last, k)]) begin
                grant_any = 1'b1;
                grant_ch  = rr_idx(last, k);
            end
        end
    end

    // The output stage takes a new winner when idle or when the current offer is accepted.
    always_comb begin
        advance   = (state == ST_IDLE) || exp_ready;
        grant_clr = (advance && grant_any) ? (NUM_CH'(1) << grant_ch) : '0;
        pend_keep = pending & ~grant_clr & ~cancel_hit;
    end

    // A granted bit is already cleared, so a fresh expiry on the offered channel is not an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= '0;
            pending  <= '0;
            overflow <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                remain[i] <= '0;
            end
        end else begin
            active   <= active_n;
            pending  <= pend_keep | expire;
            overflow <= overflow | (pend_keep & expire);
            for (int i = 0; i < NUM_CH; i++) begin
                remain[i] <= remain_n[i];
            end
        end
    end

    // Expiry output stage: holds exp_ch stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            exp_valid <= 1'b0;
            exp_ch    <= '0;
            last      <= CH_W'(NUM_CH - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        state     <= ST_OFFER;
                        exp_valid <= 1'b1;
                        exp_ch    <= grant_ch;
                        last      <= grant_ch;
                    end
                end
                ST_OFFER: begin
                    if (exp_ready) begin
                        if (grant_any) begin
                            exp_ch <= grant_ch;
                            last   <= grant_ch;
                        end else begin
                            state     <= ST_IDLE;
                            exp_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    exp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snic_timer_sched.sv
// Directed, table-driven bench for snic_timer_sched (TICK_LIMIT=4, NUM_CH=4, CNT_W=8).
// Define SNIC_TIMER_SCHED_CANCEL_EN to also exercise the cancel port.
module tb_snic_timer_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm_valid;
    logic [1:0] arm_ch;
    logic [7:0] arm_ticks;
    logic       exp_valid;
    logic [1:0] exp_ch;
    logic       exp_ready;
    logic [3:0] active;
    logic [3:0] overflow;
`ifdef SNIC_TIMER_SCHED_CANCEL_EN
    logic       cancel_valid;
    logic [1:0] cancel_ch;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    snic_timer_sched #(
        .NUM_CH     (4),
        .TICK_LIMIT (64'd4),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm_valid    (arm_valid),
        .arm_ch       (arm_ch),
        .arm_ticks    (arm_ticks),
`ifdef SNIC_TIMER_SCHED_CANCEL_EN
        .cancel_valid (cancel_valid),
        .cancel_ch    (cancel_ch),
`endif
        .exp_valid    (exp_valid),
        .exp_ch       (exp_ch),
        .exp_ready    (exp_ready),
        .active       (active),
        .overflow     (overflow)
    );

    // One row = inputs applied before an edge and the outputs required after it.
    typedef struct {
        logic       rs;
        logic       av;
        logic [1:0] ach;
        logic [7:0] atk;
        logic       rdy;
        logic       ev;
        logic [1:0] ech;
        logic [3:0] act;
        logic [3:0] ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, input logic av, input logic [1:0] ach,
                       input logic [7:0] atk, input logic rdy, input logic ev,
                       input logic [1:0] ech, input logic [3:0] act, input logic [3:0] ovf);
        vec_t v;
        v.rs = rs; v.av = av; v.ach = ach; v.atk = atk; v.rdy = rdy;
        v.ev = ev; v.ech = ech; v.act = act; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n, input logic rdy, input logic ev, input logic [1:0] ech,
                        input logic [3:0] act, input logic [3:0] ovf);
        for (int i = 0; i < n; i++) begin
            add(1'b0, 1'b0, 2'd0, 8'd0, rdy, ev, ech, act, ovf);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [1:0] ech,
                         input logic [3:0] act, input logic [3:0] ovf);
        n_cmp++;
        if (exp_valid !== ev || (ev && exp_ch !== ech) || active !== act || overflow !== ovf) begin
            n_bad++;
            $display("FAIL %s: got exp_valid=%0b exp_ch=%0d active=%b overflow=%b, want %0b %0d %b %b",
                     name, exp_valid, exp_ch, active, overflow, ev, ech, act, ovf);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        arm_valid = 1'b0;
        exp_ready = 1'b0;
`ifdef SNIC_TIMER_SCHED_CANCEL_EN
        cancel_valid = 1'b0;
`endif
        step();
        step();
        n_cmp++;
        if (exp_valid !== 1'b0 || exp_ch !== 2'd0 || active !== 4'd0 || overflow !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: got exp_valid=%0b exp_ch=%0d active=%b overflow=%b, want 0 0 0000 0000",
                     exp_valid, exp_ch, active, overflow);
        end
        rst = 1'b0;
    endtask

    initial begin
        bit clean;
        rst       = 1'b1;
        arm_valid = 1'b0;
        arm_ch    = 2'd0;
        arm_ticks = 8'd0;
        exp_ready = 1'b0;
`ifdef SNIC_TIMER_SCHED_CANCEL_EN
        cancel_valid = 1'b0;
        cancel_ch    = 2'd0;
`endif

        // Single timeout on ch2, 3 ticks; ticks land on edges 5, 9, 13.
        add(1, 1, 2'd2, 8'd3, 1, 0, 0, 4'b0100, 4'b0000);
        idle(11, 1, 0, 0, 4'b0100, 4'b0000);
        idle(1, 1, 0, 0, 4'b0000, 4'b0000);
        idle(1, 1, 1, 2'd2, 4'b0000, 4'b0000);
        idle(2, 1, 0, 0, 4'b0000, 4'b0000);

        // Four simultaneous expiries, consumer stalled for 10 cycles.
        add(1, 1, 2'd0, 8'd1, 0, 0, 0, 4'b0001, 4'b0000);
        add(0, 1, 2'd1, 8'd1, 0, 0, 0, 4'b0011, 4'b0000);
        add(0, 1, 2'd2, 8'd1, 0, 0, 0, 4'b0111, 4'b0000);
        add(0, 1, 2'd3, 8'd1, 0, 0, 0, 4'b1111, 4'b0000);
        idle(1, 0, 0, 0, 4'b0000, 4'b0000);
        idle(10, 0, 1, 2'd0, 4'b0000, 4'b0000);
        idle(1, 1, 1, 2'd1, 4'b0000, 4'b0000);
        idle(1, 1, 1, 2'd2, 4'b0000, 4'b0000);
        idle(1, 1, 1, 2'd3, 4'b0000, 4'b0000);
        idle(1, 1, 0, 0, 4'b0000, 4'b0000);

        // Re-arm ch1 in the tick cycle that would have expired it: arm wins.
        add(1, 1, 2'd1, 8'd2, 1, 0, 0, 4'b0010, 4'b0000);
        idle(7, 1, 0, 0, 4'b0010, 4'b0000);
        add(0, 1, 2'd1, 8'd2, 1, 0, 0, 4'b0010, 4'b0000);
        idle(7, 1, 0, 0, 4'b0010, 4'b0000);
        idle(1, 1, 0, 0, 4'b0000, 4'b0000);
        idle(1, 1, 1, 2'd1, 4'b0000, 4'b0000);
        idle(2, 1, 0, 0, 4'b0000, 4'b0000);

        // ch3 offered and stalled: second expiry merges, third sets overflow.
        add(1, 1, 2'd3, 8'd1, 0, 0, 0, 4'b1000, 4'b0000);
        idle(3, 0, 0, 0, 4'b1000, 4'b0000);
        idle(1, 0, 0, 0, 4'b0000, 4'b0000);
        add(0, 1, 2'd3, 8'd1, 0, 1, 2'd3, 4'b1000, 4'b0000);
        idle(2, 0, 1, 2'd3, 4'b1000, 4'b0000);
        idle(1, 0, 1, 2'd3, 4'b0000, 4'b0000);
        add(0, 1, 2'd3, 8'd1, 0, 1, 2'd3, 4'b1000, 4'b0000);
        idle(2, 0, 1, 2'd3, 4'b1000, 4'b0000);
        idle(2, 0, 1, 2'd3, 4'b0000, 4'b1000);
        idle(1, 1, 1, 2'd3, 4'b0000, 4'b1000);
        idle(2, 1, 0, 0, 4'b0000, 4'b1000);

        // Zero-length arm: immediate pending, never active.
        add(1, 1, 2'd0, 8'd0, 1, 0, 0, 4'b0000, 4'b0000);
        idle(1, 1, 1, 2'd0, 4'b0000, 4'b0000);
        idle(2, 1, 0, 0, 4'b0000, 4'b0000);

        foreach (vecs[i]) begin
            if (vecs[i].rs) begin
                do_reset();
            end
            arm_valid = vecs[i].av;
            arm_ch    = vecs[i].ach;
            arm_ticks = vecs[i].atk;
            exp_ready = vecs[i].rdy;
            step();
            check($sformatf("row%0d", i), vecs[i].ev, vecs[i].ech, vecs[i].act, vecs[i].ovf);
        end
        arm_valid = 1'b0;

        // Reset mid-offer with two channels running, racing an arm and a handshake.
        do_reset();
        arm_valid = 1'b1; arm_ch = 2'd0; arm_ticks = 8'd0; step();
        arm_ch = 2'd1; arm_ticks = 8'd2; step();
        arm_ch = 2'd2; arm_ticks = 8'd3; step();
        check("pre_reset_offer", 1'b1, 2'd0, 4'b0110, 4'b0000);
        rst = 1'b1; arm_ch = 2'd3; arm_ticks = 8'd1; exp_ready = 1'b1;
        step();
        check("reset_mid_offer", 1'b0, 2'd0, 4'b0000, 4'b0000);
        n_cmp++;
        if (exp_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_exp_ch: got %0d, want 0", exp_ch);
        end
        rst = 1'b0; arm_valid = 1'b0; exp_ready = 1'b0;
        clean = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (exp_valid !== 1'b0 || active !== 4'd0) clean = 1'b0;
        end
        n_cmp++;
        if (!clean) begin
            n_bad++;
            $display("FAIL no_event_after_reset: got a later event, want none");
        end

`ifdef SNIC_TIMER_SCHED_CANCEL_EN
        // Arm beats cancel on ch2; cancel on ch1 the cycle before its expiry tick.
        do_reset();
        exp_ready = 1'b1;
        arm_valid = 1'b1; arm_ch = 2'd1; arm_ticks = 8'd2; step();
        arm_ch = 2'd2; arm_ticks = 8'd1;
        cancel_valid = 1'b1; cancel_ch = 2'd2; step();
        arm_valid = 1'b0; cancel_valid = 1'b0;
        check("arm_beats_cancel", 1'b0, 2'd0, 4'b0110, 4'b0000);
        step(); step(); step(); step();
        check("ch2_offer", 1'b1, 2'd2, 4'b0010, 4'b0000);
        step();
        check("ch2_accepted", 1'b0, 2'd0, 4'b0010, 4'b0000);
        cancel_valid = 1'b1; cancel_ch = 2'd1; step();
        cancel_valid = 1'b0;
        check("cancel_ch1", 1'b0, 2'd0, 4'b0000, 4'b0000);
        clean = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (exp_valid !== 1'b0) clean = 1'b0;
        end
        n_cmp++;
        if (!clean) begin
            n_bad++;
            $display("FAIL no_event_after_cancel: got an expiry, want none");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snic_timer_sched.md
SNIC_TIMER_SCHED -- requirements
Module: snic_timer_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent timeout channels (2..16).
REQ-002 The block SHALL have parameter TICK_LIMIT, default 64'd50_000_000, clocks per timebase tick.
REQ-003 The block SHALL have parameter CNT_W, default 16, width of the per-channel tick count.
REQ-004 clk  input  1  sole clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 arm_valid  input  1  arm request strobe.
REQ-007 arm_ch  input  $clog2(NUM_CH)  channel to arm.
REQ-008 arm_ticks  input  CNT_W  timeout length in ticks.
REQ-009 cancel_valid  input  1  cancel request strobe (present only with SNIC_TIMER_SCHED_CANCEL_EN).
REQ-010 cancel_ch  input  $clog2(NUM_CH)  channel to cancel (present only with SNIC_TIMER_SCHED_CANCEL_EN).
REQ-011 exp_valid  output  1  expiry event available.
REQ-012 exp_ch  output  $clog2(NUM_CH)  channel of the expiry event.
REQ-013 exp_ready  input  1  consumer accepts the expiry event.
REQ-014 active  output  NUM_CH  per-channel running flag.
REQ-015 overflow  output  NUM_CH  sticky per-channel lost-expiry flag.

Function
REQ-016 Internal prescaler SHALL count 0..TICK_LIMIT-1 and assert a one-cycle registered tick on the cycle after the count equals TICK_LIMIT-1, then wrap to 0.
REQ-017 Arm SHALL be accepted every cycle arm_valid=1 (no backpressure); on the next edge it SHALL load remain[arm_ch]=arm_ticks and set active[arm_ch]=1.
REQ-018 Arm with arm_ticks=0 SHALL NOT set active but SHALL set pending[arm_ch] on the next edge.
REQ-019 Arm of an already-active channel SHALL restart it with the new count; no expiry generated for the old count.
REQ-020 On a tick, every active channel SHALL decrement remain; a channel with remain==1 SHALL clear active and set pending on that edge.
REQ-021 Arm and tick in the same cycle on the same channel: arm SHALL win (load, no decrement); other channels decrement normally.
REQ-022 Pending set on a channel whose pending bit is already 1 SHALL set overflow[ch]; pending stays 1 (events merged).
REQ-023 Output stage states: IDLE (exp_valid=0) and OFFER (exp_valid=1); IDLE->OFFER on the edge after any pending bit is 1, loading exp_ch by round-robin starting at channel (last granted + 1) mod NUM_CH, and clearing that pending bit.
REQ-024 In OFFER, exp_valid and exp_ch SHALL hold stable until exp_valid&&exp_ready; on acceptance, go to OFFER with the next round-robin winner if any pending, else IDLE (back-to-back throughput one event per cycle).
REQ-025 A new expiry on the channel currently offered SHALL set its pending bit again (not overflow).
REQ-026 Minimum latency tick-edge to exp_valid: pending set at edge E, exp_valid=1 after edge E+1.

Reset
REQ-027 On rst=1, prescaler, remain[], active, pending, overflow, exp_valid SHALL be 0, exp_ch 0, round-robin pointer to NUM_CH-1 (channel 0 first), state IDLE.
REQ-028 rst SHALL override all concurrent arm, cancel, tick and handshake activity, including mid-OFFER; no event survives reset.
REQ-029 overflow SHALL clear only on reset.

Configuration
REQ-030 With SNIC_TIMER_SCHED_CANCEL_EN defined, cancel_valid/cancel_ch SHALL exist; cancel SHALL clear active and pending of cancel_ch on the next edge (not a channel already loaded into the output stage).
REQ-031 With SNIC_TIMER_SCHED_CANCEL_EN defined, arm and cancel on the same channel in the same cycle: arm SHALL win.
REQ-032 Without SNIC_TIMER_SCHED_CANCEL_EN, the cancel ports and logic SHALL be absent; channels stop only by expiry or reset.

Verification (TICK_LIMIT=4, NUM_CH=4, CNT_W=8)
REQ-033 Arm ch2 ticks=3, exp_ready=1 -> active[2]=1 until third tick; pending at third tick edge, exp_valid=1 exp_ch=2 one cycle later for one cycle.
REQ-034 Arm ch0..ch3 ticks=1 same tick window, exp_ready=0 for 10 cycles then 1 -> exp_ch holds 0 while stalled, then 1,2,3 on consecutive cycles.
REQ-035 Arm ch1 ticks=2, re-arm ch1 ticks=2 after one tick -> single expiry four ticks after first arm, no overflow.
REQ-036 Arm ch3 ticks=1 twice across two ticks with exp_ready=0 and ch3 offered -> second merged in pending; third expiry while pending -> overflow[3]=1.
REQ-037 Arm ch0 ticks=0 -> exp_valid=1 exp_ch=0 two edges later, active[0] never 1.
REQ-038 rst pulse while exp_valid=1 and two channels active -> all outputs 0 next cycle, no later expiry; with CANCEL_EN, cancel ch1 one cycle before its expiry tick -> no event for ch1.
